// File: rtl/sd_pkg.sv
// ---------------------------------------------------------------------------
// sd_pkg
//   Shared constants and types for the SD command-line blocks.
//   - Response frame lengths (48-bit short, 136-bit R2 long).
//   - CRC7 polynomial (x^7 + x^3 + 1) and a one-bit serial update helper.
//   - Receiver FSM state encoding.
//   - Receiver shift-register and bit-counter widths, which depend on the
//     optional build macro SD_CMD_RX_R2_EN (136-bit R2 support).
// ---------------------------------------------------------------------------
package sd_pkg;

    localparam int unsigned SD_RESP_SHORT_BITS = 48;
    localparam int unsigned SD_RESP_LONG_BITS  = 136;

    localparam logic [6:0] SD_CRC7_POLY = 7'h09;

`ifdef SD_CMD_RX_R2_EN
    localparam int unsigned SD_RX_SR_BITS  = SD_RESP_LONG_BITS;
    localparam int unsigned SD_RX_CNT_BITS = 8;
`else
    localparam int unsigned SD_RX_SR_BITS  = SD_RESP_SHORT_BITS;
    localparam int unsigned SD_RX_CNT_BITS = 6;
`endif

    typedef enum logic [1:0] {
        RX_IDLE       = 2'd0,
        RX_WAIT_START = 2'd1,
        RX_RECV       = 2'd2,
        RX_DONE       = 2'd3
    } sd_rx_state_e;

    // One serial CRC7 step: message bit enters at the top, feedback taps
    // follow the polynomial.
    function automatic logic [6:0] sd_crc7_step(input logic [6:0] crc,
                                                input logic       data_bit);
        logic fb;
        fb = crc[6] ^ data_bit;
        return {crc[5:0], 1'b0} ^ (fb ? SD_CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// ---------------------------------------------------------------------------
// sd_crc7
//   Serial CRC7 generator/checker, shared by the command receiver and the
//   command transmitter. Register starts at zero.
//
//   Ports:
//     clk_i    system clock
//     rst_ni   asynchronous active-low reset
//     clear_i  synchronous clear to zero (wins over en_i)
//     en_i     advance the CRC by one message bit
//     bit_i    message bit, MSB of the frame first
//     crc_o    current CRC7 value
// ---------------------------------------------------------------------------
module sd_crc7
    import sd_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    input  logic       en_i,
    input  logic       bit_i,
    output logic [6:0] crc_o
);

    logic [6:0] crc_q;

    // NOTE: clocked state is written with non-blocking assignments so every
    // flop samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            crc_q <= 7'h00;
        end else if (clear_i) begin
            crc_q <= 7'h00;
        end else if (en_i) begin
            crc_q <= sd_crc7_step(crc_q, bit_i);
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/sd_cmd_rx.sv
// ---------------------------------------------------------------------------
// sd_cmd_rx
//   SD CMD-line response receiver. Armed by the command sequencer after the
//   last command bit, it samples CMD on each SDCLK rising-edge strobe, waits
//   for the start bit, shifts in a 48-bit response (or 136-bit R2 when built
//   with SD_CMD_RX_R2_EN), checks CRC7, transmission bit and end bit, and
//   reports the decoded fields with a one-cycle done pulse.
//
//   Build option: `define SD_CMD_RX_R2_EN adds long_i / long_o and 136-bit
//   frame support. Without it, frames are always 48 bits.
//
//   Parameters:
//     TIMEOUT_BITS  strobes to wait for a start bit before timeout (1..255)
//
//   Ports:
//     clk_i         system clock
//     rst_ni        asynchronous active-low reset
//     sdclk_rise_i  one-cycle strobe per SDCLK rising edge
//     start_i       arm pulse (ignored while busy_o)
//     long_i        expect R2 136-bit response (R2 build only)
//     cmd_i         synchronised CMD line
//     busy_o        armed or receiving
//     done_o        one-cycle result-valid pulse
//     timeout_o     no start bit within TIMEOUT_BITS strobes
//     crc_err_o     CRC7 mismatch
//     frame_err_o   transmission bit 1 or end bit 0
//     long_o        R2 bits [127:8] (R2 build only)
//     index_o       response bits [45:40]
//     arg_o         response bits [39:8]
// ---------------------------------------------------------------------------
module sd_cmd_rx
    import sd_pkg::*;
#(
    parameter int unsigned TIMEOUT_BITS = 64
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          sdclk_rise_i,
    input  logic          start_i,
`ifdef SD_CMD_RX_R2_EN
    input  logic          long_i,
`endif
    input  logic          cmd_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          timeout_o,
    output logic          crc_err_o,
    output logic          frame_err_o,
`ifdef SD_CMD_RX_R2_EN
    output logic [119:0]  long_o,
`endif
    output logic [5:0]    index_o,
    output logic [31:0]   arg_o
);

    localparam int unsigned CW = SD_RX_CNT_BITS;
    localparam int unsigned SW = SD_RX_SR_BITS;

    localparam logic [7:0]    TIMEOUT_LIMIT  = 8'(TIMEOUT_BITS);
    localparam logic [CW-1:0] LAST_SHORT     = CW'(SD_RESP_SHORT_BITS);
    localparam logic [CW-1:0] CRC_LAST_SHORT = CW'(SD_RESP_SHORT_BITS - 8);
`ifdef SD_CMD_RX_R2_EN
    localparam logic [CW-1:0] LAST_LONG      = CW'(SD_RESP_LONG_BITS);
    localparam logic [CW-1:0] CRC_FIRST_LONG = CW'(9);
    localparam logic [CW-1:0] CRC_LAST_LONG  = CW'(SD_RESP_LONG_BITS - 8);
`endif

    sd_rx_state_e    state_q, state_d;

    logic [7:0]      wait_cnt_q;
    logic [CW-1:0]   bit_cnt_q;
    logic [CW-1:0]   bit_num;
    logic [CW-1:0]   last_num;
    logic            crc_in_range;
    logic [SW-1:0]   sr_q;
    logic [SW-1:0]   sr_next;
    logic            sr_msb_unused;
    logic [6:0]      crc_val;

    logic            timeout_q;
    logic            crc_err_q;
    logic            frame_err_q;
    logic [5:0]      index_q;
    logic [31:0]     arg_q;

    // FSM control strobes
    logic            arm;
    logic            take_bit;
    logic            wait_inc;
    logic            hit_timeout;
    logic            last_bit;

    // Frame position of the bit sampled on this strobe. The counter is
    // cleared on arming, so the start bit seen in WAIT_START is bit 1.
    assign bit_num = bit_cnt_q + CW'(1);
    assign sr_next = {sr_q[SW-2:0], cmd_i};

    // The start bit shifts out of the top and is never read back.
    assign sr_msb_unused = sr_q[SW-1];

`ifdef SD_CMD_RX_R2_EN
    logic          long_q;
    logic [119:0]  long_data_q;

    // R2 CRC skips the 8 header bits and covers the 120 CID/CSD bits.
    assign last_num     = long_q ? LAST_LONG : LAST_SHORT;
    assign crc_in_range = long_q ? ((bit_num >= CRC_FIRST_LONG) && (bit_num <= CRC_LAST_LONG))
                                 : (bit_num <= CRC_LAST_SHORT);
    assign long_o       = long_data_q;
`else
    assign last_num     = LAST_SHORT;
    assign crc_in_range = (bit_num <= CRC_LAST_SHORT);
`endif

    sd_crc7 u_crc7 (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (arm),
        .en_i    (take_bit && crc_in_range),
        .bit_i   (cmd_i),
        .crc_o   (crc_val)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        arm         = 1'b0;
        take_bit    = 1'b0;
        wait_inc    = 1'b0;
        hit_timeout = 1'b0;
        last_bit    = 1'b0;

        unique case (state_q)
            RX_IDLE: begin
                if (start_i) begin
                    arm     = 1'b1;
                    state_d = RX_WAIT_START;
                end
            end

            RX_WAIT_START: begin
                if (sdclk_rise_i) begin
                    if (!cmd_i) begin
                        take_bit = 1'b1;
                        state_d  = RX_RECV;
                    end else begin
                        wait_inc = 1'b1;
                        if ((wait_cnt_q + 8'd1) == TIMEOUT_LIMIT) begin
                            hit_timeout = 1'b1;
                            state_d     = RX_DONE;
                        end
                    end
                end
            end

            RX_RECV: begin
                if (sdclk_rise_i) begin
                    take_bit = 1'b1;
                    if (bit_num == last_num) begin
                        last_bit = 1'b1;
                        state_d  = RX_DONE;
                    end
                end
            end

            RX_DONE: begin
                state_d = RX_IDLE;
            end

            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------ datapath
    // NOTE: the shift register is pure datapath that is fully overwritten by
    // every frame before being read, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (take_bit) begin
            sr_q <= sr_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            timeout_q   <= 1'b0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            index_q     <= '0;
            arg_q       <= '0;
`ifdef SD_CMD_RX_R2_EN
            long_q      <= 1'b0;
            long_data_q <= '0;
`endif
        end else begin
            if (arm) begin
                wait_cnt_q  <= '0;
                bit_cnt_q   <= '0;
                timeout_q   <= 1'b0;
                crc_err_q   <= 1'b0;
                frame_err_q <= 1'b0;
`ifdef SD_CMD_RX_R2_EN
                long_q      <= long_i;
`endif
            end

            if (wait_inc) begin
                wait_cnt_q <= wait_cnt_q + 8'd1;
            end

            if (hit_timeout) begin
                timeout_q <= 1'b1;
            end

            if (take_bit) begin
                bit_cnt_q <= bit_num;
                if ((bit_num == CW'(2)) && cmd_i) begin
                    frame_err_q <= 1'b1;
                end
            end

            // On the end bit the seven bits just before it are the received
            // CRC, and the CRC register has already stopped at its range end.
            if (last_bit) begin
                if (!cmd_i) begin
                    frame_err_q <= 1'b1;
                end
                if (crc_val != sr_q[6:0]) begin
                    crc_err_q <= 1'b1;
                end
                index_q <= sr_next[45:40];
                arg_q   <= sr_next[39:8];
`ifdef SD_CMD_RX_R2_EN
                long_data_q <= sr_next[127:8];
`endif
            end
        end
    end

    assign busy_o      = (state_q == RX_WAIT_START) || (state_q == RX_RECV);
    assign done_o      = (state_q == RX_DONE);
    assign timeout_o   = timeout_q;
    assign crc_err_o   = crc_err_q;
    assign frame_err_o = frame_err_q;
    assign index_o     = index_q;
    assign arg_o       = arg_q;

endmodule

// File: tb/tb_sd_cmd_rx.sv
// ---------------------------------------------------------------------------
// tb_sd_cmd_rx
//   Self-checking bench for sd_cmd_rx. Reference CRC7 is computed by
//   polynomial long division; frame fields come straight from the frame
//   layout. R2 cases compile only with SD_CMD_RX_R2_EN.
// ---------------------------------------------------------------------------
module tb_sd_cmd_rx;

    localparam int unsigned TIMEOUT_BITS = 64;

    logic          clk_i        = 1'b0;
    logic          rst_ni       = 1'b0;
    logic          sdclk_rise_i = 1'b0;
    logic          start_i      = 1'b0;
    logic          cmd_i        = 1'b1;
    logic          busy_o;
    logic          done_o;
    logic          timeout_o;
    logic          crc_err_o;
    logic          frame_err_o;
    logic [5:0]    index_o;
    logic [31:0]   arg_o;
`ifdef SD_CMD_RX_R2_EN
    logic          long_i = 1'b0;
    logic [119:0]  long_o;
`endif

    int total    = 0;
    int bad      = 0;
    int done_cnt = 0;

    logic [5:0]  last_idx = '0;
    logic [31:0] last_arg = '0;

    sd_cmd_rx #(.TIMEOUT_BITS(TIMEOUT_BITS)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .sdclk_rise_i (sdclk_rise_i),
        .start_i      (start_i),
`ifdef SD_CMD_RX_R2_EN
        .long_i       (long_i),
        .long_o       (long_o),
`endif
        .cmd_i        (cmd_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .timeout_o    (timeout_o),
        .crc_err_o    (crc_err_o),
        .frame_err_o  (frame_err_o),
        .index_o      (index_o),
        .arg_o        (arg_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) if (done_o) done_cnt++;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ----------------------------------------------------------- helpers
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_bit(input logic b, input int gap);
        repeat (gap) tick();
        cmd_i        = b;
        sdclk_rise_i = 1'b1;
        tick();
        sdclk_rise_i = 1'b0;
        cmd_i        = 1'b1;
    endtask

    task automatic arm();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Remainder of msg(x) * x^7 modulo x^7 + x^3 + 1; msg holds nbits,
    // first-transmitted bit in the MSB position.
    function automatic logic [6:0] ref_crc7(input logic [127:0] msg, input int nbits);
        logic [134:0] v;
        v = 135'(msg) << 7;
        for (int i = nbits + 6; i >= 7; i--)
            if (v[i]) v ^= (135'(8'h89) << (i - 7));
        return v[6:0];
    endfunction

    function automatic logic [47:0] make_short(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] m;
        m = {2'b00, idx, arg};
        return {m, ref_crc7({88'd0, m}, 40), 1'b1};
    endfunction

    // Frame is right-aligned in f; f[nbits-1] goes out first.
    task automatic send_frame(input logic [135:0] f, input int nbits, input int idle,
                              input int start_at, output int d0);
        repeat (idle) send_bit(1'b1, $urandom_range(2, 0));
        d0 = done_cnt;
        for (int n = 1; n <= nbits; n++) begin
            if (n == start_at) start_i = 1'b1;
            send_bit(f[nbits - n], (n == start_at) ? 0 : int'($urandom_range(2, 0)));
            start_i = 1'b0;
        end
    endtask

    // Called right after the strobe that should finish the frame.
    task automatic expect_done(input string tag, input int d0, input logic exp_to,
                               input logic exp_crc, input logic exp_frame,
                               input logic [5:0] exp_idx, input logic [31:0] exp_arg);
        check({tag, ":done"},  done_o, 1'b1);
        check({tag, ":early"}, done_cnt, d0);
        check({tag, ":busy"},  busy_o, 1'b0);
        check({tag, ":tmo"},   timeout_o, exp_to);
        check({tag, ":crc"},   crc_err_o, exp_crc);
        check({tag, ":frm"},   frame_err_o, exp_frame);
        check({tag, ":idx"},   index_o, exp_idx);
        check({tag, ":arg"},   arg_o, exp_arg);
        tick();
        check({tag, ":pulse"}, done_o, 1'b0);
        check({tag, ":count"}, done_cnt, d0 + 1);
    endtask

    task automatic recv_short(input string tag, input logic [47:0] f, input int idle,
                              input int start_at);
        int   d0;
        logic crc_bad;
        send_frame({88'd0, f}, 48, idle, start_at, d0);
        crc_bad  = (ref_crc7({88'd0, f[47:8]}, 40) != f[7:1]);
        last_idx = f[45:40];
        last_arg = f[39:8];
        expect_done(tag, d0, 1'b0, crc_bad, f[46] | ~f[0], f[45:40], f[39:8]);
    endtask

    task automatic run_short(input string tag, input logic [47:0] f, input int idle,
                             input int start_at);
        arm();
        recv_short(tag, f, idle, start_at);
    endtask

    // ----------------------------------------------------------- stimulus
    initial begin
        int          d0;
        logic [47:0] f;
        logic [47:0] r7;

        r7 = 48'h08_00_00_01_AA_13;

        // Reset state
        repeat (3) tick();
        check("rst0:busy", busy_o, 1'b0);
        check("rst0:done", done_o, 1'b0);
        check("rst0:tmo",  timeout_o, 1'b0);
        check("rst0:crc",  crc_err_o, 1'b0);
        check("rst0:frm",  frame_err_o, 1'b0);
        check("rst0:idx",  index_o, 6'd0);
        check("rst0:arg",  arg_o, 32'd0);
`ifdef SD_CMD_RX_R2_EN
        check("rst0:long", long_o, 120'd0);
`endif
        rst_ni = 1'b1;
        tick();

        // Known-good R7 after 5 idle-high strobes
        arm();
        check("arm:busy", busy_o, 1'b1);
        send_frame({88'd0, r7}, 48, 5, 0, d0);
        expect_done("r7", d0, 1'b0, 1'b0, 1'b0, 6'd8, 32'h0000_01AA);

        // Bit 30 flipped: CRC error only
        arm();
        f = r7 ^ (48'd1 << (48 - 30));
        send_frame({88'd0, f}, 48, 2, 0, d0);
        expect_done("bit30", d0, 1'b0, 1'b1, 1'b0, f[45:40], f[39:8]);

        // End bit 0: frame error only
        arm();
        f = r7 & ~48'd1;
        send_frame({88'd0, f}, 48, 1, 0, d0);
        expect_done("endbit", d0, 1'b0, 1'b0, 1'b1, 6'd8, 32'h0000_01AA);

        // Transmission bit 1
        run_short("txbit", r7 | (48'd1 << 46), 0, 0);

        // Randomised frames with optional corruption and mid-frame start pulses
        for (int k = 0; k < 20; k++) begin
            f = make_short(6'($urandom), $urandom);
            case ($urandom_range(3, 0))
                1:       f[$urandom_range(46, 1)] ^= 1'b1;
                2:       f[0] = 1'b0;
                default: ;
            endcase
            run_short("rand", f, $urandom_range(10, 0),
                      ($urandom_range(1, 0) == 1) ? int'($urandom_range(47, 2)) : 0);
        end

        // Timeout: CMD held high for TIMEOUT_BITS strobes
        arm();
        d0 = done_cnt;
        for (int k = 1; k < TIMEOUT_BITS; k++) send_bit(1'b1, $urandom_range(2, 0));
        check("tmo:busy63",  busy_o, 1'b1);
        check("tmo:nodone",  done_cnt, d0);
        send_bit(1'b1, $urandom_range(2, 0));
        expect_done("tmo", d0, 1'b1, 1'b0, 1'b0, last_idx, last_arg);

        // Start bit exactly on strobe TIMEOUT_BITS
        run_short("edge64", make_short(6'h11, 32'hCAFE_0123), TIMEOUT_BITS - 1, 0);

        // Start and strobe in the same cycle: arm only, no sample
        start_i = 1'b1; sdclk_rise_i = 1'b1; cmd_i = 1'b0;
        tick();
        start_i = 1'b0; sdclk_rise_i = 1'b0; cmd_i = 1'b1;
        recv_short("samecyc", make_short(6'h2C, 32'h1357_9BDF), 2, 0);

        // Reset in the middle of a frame, at bit 20
        arm();
        f  = make_short(6'h2A, 32'hDEAD_BEEF);
        d0 = done_cnt;
        for (int n = 1; n <= 20; n++) send_bit(f[48 - n], $urandom_range(2, 0));
        #2 rst_ni = 1'b0;
        #1;
        check("rstmid:busy", busy_o, 1'b0);
        check("rstmid:done", done_o, 1'b0);
        check("rstmid:tmo",  timeout_o, 1'b0);
        check("rstmid:crc",  crc_err_o, 1'b0);
        check("rstmid:frm",  frame_err_o, 1'b0);
        check("rstmid:idx",  index_o, 6'd0);
        check("rstmid:arg",  arg_o, 32'd0);
        tick();
        check("rstmid:nodone", done_cnt, d0);
        rst_ni   = 1'b1;
        last_idx = '0;
        last_arg = '0;
        tick();

        // Valid R7 after reset, with a start pulse mid-frame
        run_short("afterrst", r7, 3, 25);

`ifdef SD_CMD_RX_R2_EN
        // R2 long responses; the last one has a corrupted CID bit
        for (int k = 0; k < 3; k++) begin
            logic [119:0] pl;
            logic [135:0] lf;
            int           dl;
            pl = {$urandom, $urandom, $urandom, 24'($urandom)};
            lf = {2'b00, 6'b111111, pl, ref_crc7({8'd0, pl}, 120), 1'b1};
            if (k == 2) lf[60] ^= 1'b1;
            long_i = 1'b1;
            arm();
            long_i = 1'b0;
            send_frame(lf, 136, $urandom_range(5, 0), 0, dl);
            expect_done("r2", dl, 1'b0, ref_crc7({8'd0, lf[127:8]}, 120) != lf[7:1],
                        lf[134] | ~lf[0], lf[45:40], lf[39:8]);
            check("r2:long", long_o, lf[127:8]);
            last_idx = lf[45:40];
            last_arg = lf[39:8];
        end
        run_short("r2build_short", r7, 1, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
